// File: rtl/pool_layer_ctrl_pkg.sv
// Shared types and default geometry for the LeNet pooling-layer sequencer.
// Defaults describe the 2-lane, 14-column, 5-rows-per-word configuration.
package pool_layer_ctrl_pkg;

  localparam int DEF_DW            = 16;
  localparam int DEF_COLS          = 14;
  localparam int DEF_PACK          = 5;
  localparam int DEF_NUM_LANES     = 2;
  localparam int DEF_ROWS_PER_LANE = 42;
  localparam int DEF_RD_AW         = 7;
  localparam int DEF_WR_AW         = 5;
  localparam int DEF_RD_LAT        = 2;
  localparam int DEF_POOL_LAT      = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FLUSH = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/pool_layer_ctrl_pack_buf.sv
// Per-lane packer: collects PACK pooled rows into one wide word, first row in the
// top slot, and emits a one-cycle write strobe when full or when flushed.
module pool_layer_ctrl_pack_buf #(
  parameter int RW   = 224,
  parameter int PACK = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               row_vld,
  input  logic               flush,
  input  logic [RW-1:0]      row_data,
  output logic               wr_stb,
  output logic [PACK*RW-1:0] word,
  output logic               pending
);

  localparam int CW = (PACK > 1) ? $clog2(PACK) : 1;

  logic [CW-1:0]      cnt;
  logic [PACK*RW-1:0] acc_q;
  logic [PACK*RW-1:0] fill;

  // Slot cnt counts down from the MSB end of the word.
  always_comb begin
    fill = acc_q;
    for (int s = 0; s < PACK; s++) begin
      if (cnt == CW'(s)) fill[(PACK-1-s)*RW +: RW] = row_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      acc_q  <= '0;
      word   <= '0;
      wr_stb <= 1'b0;
    end else begin
      wr_stb <= 1'b0;
      if (clear) begin
        cnt   <= '0;
        acc_q <= '0;
      end else if (flush) begin
        // Unfilled low slots are still zero from the last clear.
        word   <= acc_q;
        wr_stb <= 1'b1;
        cnt    <= '0;
        acc_q  <= '0;
      end else if (row_vld) begin
        if (cnt == CW'(PACK-1)) begin
          word   <= fill;
          wr_stb <= 1'b1;
          cnt    <= '0;
          acc_q  <= '0;
        end else begin
          acc_q <= fill;
          cnt   <= cnt + 1'b1;
        end
      end
    end
  end

  assign pending = (cnt != '0);

endmodule

// File: rtl/pool_layer_ctrl.sv
// Pooling-layer sequencer: reads conv rows on NUM_LANES ports, times the shared
// max-pool unit through a valid pipe and writes packed pooled rows back out.
module pool_layer_ctrl
  import pool_layer_ctrl_pkg::*;
#(
  parameter int DW            = DEF_DW,
  parameter int COLS          = DEF_COLS,
  parameter int PACK          = DEF_PACK,
  parameter int NUM_LANES     = DEF_NUM_LANES,
  parameter int ROWS_PER_LANE = DEF_ROWS_PER_LANE,
  parameter int RD_AW         = DEF_RD_AW,
  parameter int WR_AW         = DEF_WR_AW,
  parameter int WR_STRIDE     = ceil_div(ROWS_PER_LANE, PACK),
  parameter int RD_LAT        = DEF_RD_LAT,
  parameter int POOL_LAT      = DEF_POOL_LAT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [NUM_LANES*COLS*DW-1:0]      pool_res,
  output logic                             pool_req,
  output logic                             rd_en,
  output logic [NUM_LANES*RD_AW-1:0]        rd_addr,
  output logic                             wr_en,
  output logic [NUM_LANES*WR_AW-1:0]        wr_addr,
  output logic [NUM_LANES*PACK*COLS*DW-1:0] wr_data,
  output logic                             busy,
  output logic                             done,
  output logic [2:0]                       state_dbg
);

  localparam int RW       = COLS * DW;
  localparam int WORD_W   = PACK * RW;
  localparam int PIPE_LEN = RD_LAT + POOL_LAT;
  localparam int RCW      = $clog2(ROWS_PER_LANE + 1);

  // Handshake: rd_en, pool_req, res_vld and wr_en are single-cycle strobes with
  // no backpressure; data beside a strobe is valid exactly in that cycle.
  state_t               state;
  logic                 start_d;
  logic                 launch;
  logic                 flush;
  logic [RCW-1:0]       rd_cnt;
  logic [PIPE_LEN-1:0]  vpipe;
  logic                 res_vld;
  logic [NUM_LANES-1:0] wr_stb_v;
  logic [NUM_LANES-1:0] pend_v;
  logic                 pending;

  assign launch    = (state == ST_IDLE) && start && !start_d;
  assign pool_req  = vpipe[RD_LAT-1];
  assign res_vld   = vpipe[PIPE_LEN-1];
  assign wr_en     = &wr_stb_v;
  assign pending   = |pend_v;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      start_d <= 1'b0;
      rd_en   <= 1'b0;
      rd_cnt  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      flush   <= 1'b0;
      vpipe   <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        rd_addr[l*RD_AW +: RD_AW] <= RD_AW'(l * ROWS_PER_LANE);
        wr_addr[l*WR_AW +: WR_AW] <= WR_AW'(l * WR_STRIDE);
      end
    end else begin
      start_d <= start;
      vpipe   <= {vpipe[PIPE_LEN-2:0], rd_en};
      if (wr_en) begin
        for (int l = 0; l < NUM_LANES; l++)
          wr_addr[l*WR_AW +: WR_AW] <= wr_addr[l*WR_AW +: WR_AW] + WR_AW'(1);
      end
      case (state)
        ST_IDLE: begin
          if (launch) begin
            state  <= ST_READ;
            rd_en  <= 1'b1;
            rd_cnt <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
            for (int l = 0; l < NUM_LANES; l++) begin
              rd_addr[l*RD_AW +: RD_AW] <= RD_AW'(l * ROWS_PER_LANE);
              wr_addr[l*WR_AW +: WR_AW] <= WR_AW'(l * WR_STRIDE);
            end
          end
        end
        ST_READ: begin
          rd_cnt <= rd_cnt + 1'b1;
          if (rd_cnt == RCW'(ROWS_PER_LANE - 1)) begin
            rd_en <= 1'b0;
            state <= ST_DRAIN;
          end else begin
            for (int l = 0; l < NUM_LANES; l++)
              rd_addr[l*RD_AW +: RD_AW] <= rd_addr[l*RD_AW +: RD_AW] + RD_AW'(1);
          end
        end
        ST_DRAIN: begin
          // Once the pipe is empty every pooled row has reached its packer.
          if (vpipe == '0) begin
            if (pending) begin
              state <= ST_FLUSH;
              flush <= 1'b1;
            end else begin
              state <= ST_FIN;
            end
          end
        end
        ST_FLUSH: begin
          flush <= 1'b0;
          state <= ST_FIN;
        end
        ST_FIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    pool_layer_ctrl_pack_buf #(
      .RW   (RW),
      .PACK (PACK)
    ) u_pack_buf (
      .clk      (clk),
      .rst      (rst),
      .clear    (launch),
      .row_vld  (res_vld),
      .flush    (flush),
      .row_data (pool_res[l*RW +: RW]),
      .wr_stb   (wr_stb_v[l]),
      .word     (wr_data[l*WORD_W +: WORD_W]),
      .pending  (pend_v[l])
    );
  end

endmodule

// File: tb/tb_pool_layer_ctrl.sv
// Bench for pool_layer_ctrl: BRAM + max-pool model feeding both a 42-row and a
// 40-row instance, with a queue scoreboard of expected packed writes.
module tb_pool_layer_ctrl;
  import pool_layer_ctrl_pkg::*;

  localparam int DW       = 16;
  localparam int COLS     = 14;
  localparam int PACK     = 5;
  localparam int NL       = 2;
  localparam int RD_AW    = 7;
  localparam int WR_AW    = 5;
  localparam int RD_LAT   = 2;
  localparam int POOL_LAT = 3;
  localparam int RW       = COLS * DW;
  localparam int WORD_W   = PACK * RW;
  localparam int PRW      = NL * RW;
  localparam int WDW      = NL * WORD_W;
  localparam int MEM_N    = NL * 42;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start_a, pool_req_a, rd_en_a, wr_en_a, busy_a, done_a;
  logic [NL*RD_AW-1:0] rd_addr_a;
  logic [NL*WR_AW-1:0] wr_addr_a;
  logic [WDW-1:0]    wr_data_a;
  logic [2:0]        state_a;
  logic              start_b, pool_req_b, rd_en_b, wr_en_b, busy_b, done_b;
  logic [NL*RD_AW-1:0] rd_addr_b;
  logic [NL*WR_AW-1:0] wr_addr_b;
  logic [WDW-1:0]    wr_data_b;
  logic [2:0]        state_b;
  logic [PRW-1:0]    pool_res;

  pool_layer_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start_a), .pool_res(pool_res), .pool_req(pool_req_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
    .wr_data(wr_data_a), .busy(busy_a), .done(done_a), .state_dbg(state_a)
  );

  pool_layer_ctrl #(.ROWS_PER_LANE(40), .WR_STRIDE(8)) u_dut40 (
    .clk(clk), .rst(rst), .start(start_b), .pool_res(pool_res), .pool_req(pool_req_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .busy(busy_b), .done(done_b), .state_dbg(state_b)
  );

  logic sel;
  int   rows, stride;
  logic                m_pool_req, m_rd_en, m_wr_en, m_busy, m_done;
  logic [NL*RD_AW-1:0] m_rd_addr;
  logic [NL*WR_AW-1:0] m_wr_addr;
  logic [WDW-1:0]      m_wr_data;
  logic [2:0]          m_state;
  assign m_pool_req = sel ? pool_req_b : pool_req_a;
  assign m_rd_en    = sel ? rd_en_b    : rd_en_a;
  assign m_wr_en    = sel ? wr_en_b    : wr_en_a;
  assign m_busy     = sel ? busy_b     : busy_a;
  assign m_done     = sel ? done_b     : done_a;
  assign m_rd_addr  = sel ? rd_addr_b  : rd_addr_a;
  assign m_wr_addr  = sel ? wr_addr_b  : wr_addr_a;
  assign m_wr_data  = sel ? wr_data_b  : wr_data_a;
  assign m_state    = sel ? state_b    : state_a;

  // scoreboard state
  typedef struct {
    int             due;
    logic [PRW-1:0] data;
  } pend_t;

  logic [WDW-1:0]      exp_q[$];
  logic [NL*WR_AW-1:0] exp_addr_q[$];
  pend_t               pend_q[$];
  logic [RW-1:0]       mem [MEM_N];
  int checks = 0, failures = 0;
  int cyc = 0;
  int rd_total = 0, wr_total = 0, fl_total = 0;
  int rd_mark = 0, wr_mark = 0, fl_mark = 0;
  logic [7:0]        rd_hist = '0;
  logic [WORD_W-1:0] first_w0, last_w0;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endfunction

  function automatic void chk_slots(input string name, input logic [WORD_W-1:0] got,
                                    input logic [WORD_W-1:0] exp);
    int bad;
    bad = -1;
    checks++;
    for (int s = 0; s < PACK; s++)
      if (bad < 0 && got[s*RW +: RW] !== exp[s*RW +: RW]) bad = s;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s slot=%0d got=%h exp=%h", name, bad, got[bad*RW +: RW], exp[bad*RW +: RW]);
    end
  endfunction

  function automatic logic [63:0] lane_vec(input int step, input int ofs, input int aw);
    logic [63:0] v;
    v = '0;
    for (int l = 0; l < NL; l++) v = v | (64'((l + ofs) * step) << (l * aw));
    return v;
  endfunction

  // BRAM + pool model and write scoreboard
  always @(negedge clk) begin
    logic [PRW-1:0] d;
    logic [WDW-1:0] e;
    logic [NL*WR_AW-1:0] ea;
    pend_t p;
    int idx;
    cyc++;
    for (int i = 0; i < PRW / 32; i++) pool_res[i*32 +: 32] = $urandom();
    if (rst) begin
      pend_q.delete();
      rd_hist = '0;
    end else begin
      rd_hist = {rd_hist[6:0], m_rd_en};
      if (m_pool_req || rd_hist[RD_LAT])
        chk("pool_req_align", 64'(m_pool_req), 64'(rd_hist[RD_LAT]));
      if (m_state == ST_FLUSH) fl_total++;
      if (m_rd_en) begin
        idx = rd_total - rd_mark;
        if (idx >= rows) begin
          checks++;
          failures++;
          $display("FAIL rd_overrun idx=%0d rows=%0d", idx, rows);
        end else begin
          for (int l = 0; l < NL; l++) begin
            chk("rd_addr", 64'(m_rd_addr[l*RD_AW +: RD_AW]), 64'(l * rows + idx));
            d[l*RW +: RW] = mem[l*rows + idx];
          end
          p.due  = cyc + RD_LAT + POOL_LAT;
          p.data = d;
          pend_q.push_back(p);
        end
        rd_total++;
      end
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        pool_res = pend_q[0].data;
        void'(pend_q.pop_front());
      end
      if (m_wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_unexpected got_addr=%0h exp=none", m_wr_addr);
        end else begin
          e  = exp_q.pop_front();
          ea = exp_addr_q.pop_front();
          chk("wr_addr", 64'(m_wr_addr), 64'(ea));
          for (int l = 0; l < NL; l++)
            chk_slots($sformatf("wr_data_l%0d", l), m_wr_data[l*WORD_W +: WORD_W], e[l*WORD_W +: WORD_W]);
        end
        if (wr_total == wr_mark) first_w0 = m_wr_data[WORD_W-1:0];
        last_w0 = m_wr_data[WORD_W-1:0];
        wr_total++;
      end
    end
  end

  // reference model: rows grouped PACK at a time, first row in top slot, short tail zero
  task automatic fill_mem(input int mode);
    for (int a = 0; a < NL * rows; a++) begin
      for (int c = 0; c < COLS; c++)
        mem[a][c*DW +: DW] = mode ? DW'(a % rows) : DW'($urandom_range(0, 65535));
    end
  endtask

  task automatic build_expected();
    logic [WDW-1:0] e;
    logic [NL*WR_AW-1:0] ea;
    for (int w = 0; w < stride; w++) begin
      e  = '0;
      ea = '0;
      for (int l = 0; l < NL; l++) begin
        ea[l*WR_AW +: WR_AW] = WR_AW'(l * stride + w);
        for (int j = 0; j < PACK; j++)
          if (w * PACK + j < rows) e[l*WORD_W + (PACK-1-j)*RW +: RW] = mem[l*rows + w*PACK + j];
      end
      exp_q.push_back(e);
      exp_addr_q.push_back(ea);
    end
  endtask

  // driver tasks
  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else start_a = v;
  endtask

  task automatic select(input logic s);
    sel    = s;
    rows   = s ? 40 : 42;
    stride = (rows + PACK - 1) / PACK;
  endtask

  task automatic prep_pass(input int mode);
    fill_mem(mode);
    build_expected();
    rd_mark = rd_total;
    wr_mark = wr_total;
    fl_mark = fl_total;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, 64'(m_rd_en), 64'd0);
    chk({tag, "_wr_en"}, 64'(m_wr_en), 64'd0);
    chk({tag, "_pool_req"}, 64'(m_pool_req), 64'd0);
    chk({tag, "_busy"}, 64'(m_busy), 64'd0);
    chk({tag, "_done"}, 64'(m_done), 64'd0);
    chk({tag, "_state"}, 64'(m_state), 64'(ST_IDLE));
    chk({tag, "_rd_addr"}, 64'(m_rd_addr), lane_vec(rows, 0, RD_AW));
    chk({tag, "_wr_addr"}, 64'(m_wr_addr), lane_vec(stride, 0, WR_AW));
    chk_slots({tag, "_wr_data"}, m_wr_data[WORD_W-1:0], '0);
  endtask

  task automatic run_pass(input logic s, input int mode, input bit repulse, input bit hold);
    int n;
    select(s);
    prep_pass(mode);
    @(posedge clk); #1 set_start(1'b1);
    @(posedge clk); #1;
    chk("busy_at_launch", 64'(m_busy), 64'd1);
    chk("done_at_launch", 64'(m_done), 64'd0);
    if (!hold) set_start(1'b0);
    if (repulse) begin
      repeat (8) @(posedge clk);
      #1 set_start(1'b1);
      @(posedge clk); #1 set_start(1'b0);
    end
    n = 0;
    while (!m_done && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!m_done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout got=0 exp=1 after %0d cycles", n);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rd_count", 64'(rd_total - rd_mark), 64'(rows));
    chk("wr_count", 64'(wr_total - wr_mark), 64'(stride));
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("busy_end", 64'(m_busy), 64'd0);
    chk("done_end", 64'(m_done), 64'd1);
    chk("flush_entered", 64'(fl_total != fl_mark), 64'((rows % PACK) != 0));
    chk("wr_addr_end", 64'(m_wr_addr), lane_vec(stride, 1, WR_AW));
  endtask

  initial begin
    logic [WORD_W-1:0] w0, w8;
    int busy_seen;
    start_a = 1'b0;
    start_b = 1'b0;
    select(1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");
    rst = 1'b0;

    // row k carries k in every element
    run_pass(1'b0, 1, 1'b0, 1'b0);
    w0 = '0;
    w8 = '0;
    for (int j = 0; j < PACK; j++)
      for (int c = 0; c < COLS; c++) begin
        w0[(PACK-1-j)*RW + c*DW +: DW] = DW'(j);
        if (j < 2) w8[(PACK-1-j)*RW + c*DW +: DW] = DW'(40 + j);
      end
    chk_slots("word0_lane0", first_w0, w0);
    chk_slots("word8_lane0_flush", last_w0, w8);

    run_pass(1'b0, 0, 1'b1, 1'b0);
    run_pass(1'b1, 1, 1'b0, 1'b0);
    run_pass(1'b1, 0, 1'b0, 1'b0);

    // reset in the middle of READ
    select(1'b0);
    prep_pass(0);
    @(posedge clk); #1 set_start(1'b1);
    @(posedge clk); #1 set_start(1'b0);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("mid_rst");
    exp_q.delete();
    exp_addr_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_pass(1'b0, 0, 1'b0, 1'b0);

    // start held high: one pass only, then a fresh rise relaunches
    run_pass(1'b0, 0, 1'b0, 1'b1);
    busy_seen = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (m_busy) busy_seen++;
    end
    chk("hold_no_relaunch", 64'(busy_seen), 64'd0);
    chk("hold_done_kept", 64'(m_done), 64'd1);
    set_start(1'b0);
    run_pass(1'b0, 0, 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 20)) @(posedge clk);
      run_pass(1'($urandom_range(0, 1)), 0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
